// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit with architectural HI/LO registers.
// Shift-add multiply and restoring divide, BITS_PER_CYCLE bits per edge.
module muldiv_unit #(
    parameter int WIDTH          = 32,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int ITERS = WIDTH / BITS_PER_CYCLE;
    localparam int CW = $clog2(ITERS + 1);
    localparam logic [CW-1:0] LAST = CW'(ITERS - 1);

    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;
    state_t state, state_n;

    logic [CW-1:0]      cnt;
    logic               is_div, neg_res, neg_rem, dz;
    logic [WIDTH-1:0]   x, m;
    logic [2*WIDTH-1:0] acc;

    logic [WIDTH-1:0]   x_n;
    logic [2*WIDTH-1:0] acc_n;
    logic [WIDTH:0]     r;

    logic               go, mthi, mtlo, sgn, sa, sb;
    logic [WIDTH-1:0]   abs_a, abs_b;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   rem_mag, hi_fix, lo_fix;

    assign busy  = (state != IDLE);
    assign go    = start && !busy && !op[2];
    assign mthi  = start && !busy && (op == 3'b100);
    assign mtlo  = start && !busy && (op == 3'b101);
    assign sgn   = ~op[0];
    assign sa    = sgn & a[WIDTH-1];
    assign sb    = sgn & b[WIDTH-1];
    assign abs_a = sa ? -a : a;
    assign abs_b = sb ? -b : b;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_n;
    end

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE:    if (go) state_n = CALC;
            CALC:    if (cnt == LAST) state_n = FIX;
            FIX:     state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // x is the multiplier (consumed MSB first) or dividend becoming quotient
    always_comb begin
        acc_n = acc;
        x_n   = x;
        r     = '0;
        for (int i = 0; i < BITS_PER_CYCLE; i++) begin
            if (is_div) begin
                r   = {acc_n[WIDTH-1:0], x_n[WIDTH-1]};
                x_n = x_n << 1;
                if (r >= {1'b0, m}) begin
                    r      = r - {1'b0, m};
                    x_n[0] = 1'b1;
                end
                acc_n = {{(WIDTH-1){1'b0}}, r};
            end else begin
                acc_n = acc_n << 1;
                if (x_n[WIDTH-1])
                    acc_n = acc_n + {{WIDTH{1'b0}}, m};
                x_n = x_n << 1;
            end
        end
    end

    always_comb begin
        prod    = neg_res ? -acc : acc;
        rem_mag = acc[WIDTH-1:0];
        if (is_div) begin
            hi_fix = neg_rem ? -rem_mag : rem_mag;
            lo_fix = dz ? '1 : (neg_res ? -x : x);
        end else begin
            hi_fix = prod[2*WIDTH-1:WIDTH];
            lo_fix = prod[WIDTH-1:0];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt      <= '0;
            is_div   <= 1'b0;
            neg_res  <= 1'b0;
            neg_rem  <= 1'b0;
            dz       <= 1'b0;
            x        <= '0;
            m        <= '0;
            acc      <= '0;
            hi       <= '0;
            lo       <= '0;
            done     <= 1'b0;
            div_zero <= 1'b0;
        end else begin
            done     <= 1'b0;
            div_zero <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (go) begin
                        cnt     <= '0;
                        is_div  <= op[1];
                        neg_res <= sa ^ sb;
                        neg_rem <= sa;
                        dz      <= op[1] && (b == '0);
                        x       <= op[1] ? abs_a : abs_b;
                        m       <= op[1] ? abs_b : abs_a;
                        acc     <= '0;
                    end
                    if (mthi) hi <= a;
                    if (mtlo) lo <= a;
                end
                CALC: begin
                    cnt <= cnt + 1'b1;
                    x   <= x_n;
                    acc <= acc_n;
                end
                FIX: begin
                    hi       <= hi_fix;
                    lo       <= lo_fix;
                    done     <= 1'b1;
                    div_zero <= dz;
                end
                default: ;
            endcase
        end
    end

endmodule
